rs_encoder_lfsr: RTL and testbench

Systematic Reed-Solomon encoder on the multi-symbol AXI-Stream bus, the transmit-side counterpart of the syndrome calculator. It passes message beats through unchanged while a generator-polynomial LFSR, unrolled across the kept lanes of each beat, accumulates the remainder. After the last message beat it appends the parity symbols as extra beats. The codeword it produces is the input to the channel/decoder path, where every syndrome at the generator roots must evaluate to zero.

---
 rtl/gf_pkg.sv | 49 ++++
 rtl/rs_encoder_lfsr_if.sv | 17 +
 rtl/rs_lfsr_step.sv | 30 +++
 rtl/rs_encoder_lfsr.sv | 158 +++++++++++++++
 tb/tb_rs_encoder_lfsr.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^8) arithmetic and bus constants, plus the Reed-Solomon
// encoder helpers that derive parity-beat geometry from the generator degree.
package gf_pkg;

  localparam int SYMB_WIDTH        = 8;
  localparam int BUS_WIDTH_IN_SYMB = 4;
  // Primitive polynomial x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

  // Encoder phase: message pass-through, then parity emission
  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } rs_state_e;

  // Shift-and-add multiply with on-the-fly reduction by PRIM_POLY
  function automatic logic [SYMB_WIDTH-1:0] gf_mult(
    input logic [SYMB_WIDTH-1:0] a,
    input logic [SYMB_WIDTH-1:0] b
  );
    logic [SYMB_WIDTH-1:0] p;
    logic [SYMB_WIDTH-1:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < SYMB_WIDTH; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[SYMB_WIDTH-2:0], 1'b0} ^ (aa[SYMB_WIDTH-1] ? PRIM_POLY[SYMB_WIDTH-1:0] : '0);
    end
    return p;
  endfunction

  // Number of output beats needed to carry all parity symbols
  function automatic int rs_parity_beats(input int roots);
    return (roots + BUS_WIDTH_IN_SYMB - 1) / BUS_WIDTH_IN_SYMB;
  endfunction

  // Lane mask of the final parity beat: the low ((roots-1) mod bus)+1 lanes
  function automatic logic [BUS_WIDTH_IN_SYMB-1:0] rs_last_keep(input int roots);
    logic [BUS_WIDTH_IN_SYMB-1:0] m;
    int n;
    n = ((roots - 1) % BUS_WIDTH_IN_SYMB) + 1;
    m = '0;
    for (int i = 0; i < BUS_WIDTH_IN_SYMB; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rs_encoder_lfsr_if.sv
// Multi-symbol AXI-Stream bundle used on both sides of the encoder.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; once tvalid is raised, the master keeps tvalid, tdata,
// tkeep and tlast unchanged until that transfer happens.
interface rs_encoder_lfsr_if;
  import gf_pkg::*;

  logic                                    tvalid;
  logic                                    tready;
  logic [BUS_WIDTH_IN_SYMB*SYMB_WIDTH-1:0] tdata;
  logic                                    tlast;
  logic [BUS_WIDTH_IN_SYMB-1:0]            tkeep;

  modport master (output tvalid, output tdata, output tlast, output tkeep, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tkeep, output tready);

endinterface

// File: rtl/rs_lfsr_step.sv
// One symbol of the systematic RS division LFSR. A cleared keep bit makes
// the stage transparent so partial final beats fold in only real symbols.
module rs_lfsr_step
  import gf_pkg::*;
#(
  parameter int ROOTS_NUM = 4
) (
  input  logic [SYMB_WIDTH-1:0]                i_d,
  input  logic                                 i_keep,
  input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] i_r,
  input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] i_g,
  output logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] o_r
);

  logic [SYMB_WIDTH-1:0] w_fb;

  assign w_fb = i_d ^ i_r[ROOTS_NUM-1];

  // Shift the remainder up one degree and subtract fb * g(x)
  always_comb begin
    o_r = i_r;
    if (i_keep) begin
      o_r[0] = gf_mult(i_g[0], w_fb);
      for (int j = 1; j < ROOTS_NUM; j++) begin
        o_r[j] = i_r[j-1] ^ gf_mult(i_g[j], w_fb);
      end
    end
  end

endmodule

// File: rtl/rs_encoder_lfsr.sv
// Systematic Reed-Solomon encoder. Message beats pass straight through a
// single output register while an unrolled LFSR divides by g(x); after the
// last message beat the remainder is appended as dedicated parity beats,
// highest-degree remainder symbol first.
module rs_encoder_lfsr
  import gf_pkg::*;
#(
  parameter int ROOTS_NUM = 4
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] gen_poly,
  rs_encoder_lfsr_if.slave                     s_axis,
  rs_encoder_lfsr_if.master                    m_axis,
  output rs_state_e                            o_dbg_state
);

  localparam int                           P_BEATS   = rs_parity_beats(ROOTS_NUM);
  localparam int                           CNT_W     = (P_BEATS > 1) ? $clog2(P_BEATS) : 1;
  localparam int                           PAD_BEATS = 1 << CNT_W;
  localparam logic [CNT_W-1:0]             CNT_LAST  = CNT_W'(P_BEATS - 1);
  localparam logic [BUS_WIDTH_IN_SYMB-1:0] LAST_KEEP = rs_last_keep(ROOTS_NUM);
  localparam int                           BUS_W     = BUS_WIDTH_IN_SYMB * SYMB_WIDTH;

  rs_state_e                            r_state;
  rs_state_e                            w_state_nxt;
  logic [CNT_W-1:0]                     r_cnt;
  logic [CNT_W-1:0]                     w_cnt_nxt;
  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] r_lfsr;
  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] r_parity;
  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] w_chain [BUS_WIDTH_IN_SYMB+1];

  logic                         r_m_tvalid;
  logic [BUS_W-1:0]             r_m_tdata;
  logic                         r_m_tlast;
  logic [BUS_WIDTH_IN_SYMB-1:0] r_m_tkeep;

  logic             w_out_free;
  logic             w_s_fire;
  logic             w_par_last;
  logic [BUS_W-1:0] w_par_data;
  logic [BUS_W-1:0] w_beats [PAD_BEATS];

  // The output register can take a new beat when empty or draining this cycle
  assign w_out_free    = !r_m_tvalid || m_axis.tready;
  assign s_axis.tready = (r_state == ST_DATA) && w_out_free;
  assign w_s_fire      = s_axis.tvalid && s_axis.tready;

  assign m_axis.tvalid = r_m_tvalid;
  assign m_axis.tdata  = r_m_tdata;
  assign m_axis.tlast  = r_m_tlast;
  assign m_axis.tkeep  = r_m_tkeep;
  assign o_dbg_state   = r_state;

  // LFSR unrolled across lanes, lane 0 (highest degree) first
  assign w_chain[0] = r_lfsr;

  for (genvar i = 0; i < BUS_WIDTH_IN_SYMB; i++) begin : g_lane
    rs_lfsr_step #(
      .ROOTS_NUM (ROOTS_NUM)
    ) u_step (
      .i_d    (s_axis.tdata[i*SYMB_WIDTH +: SYMB_WIDTH]),
      .i_keep (s_axis.tkeep[i]),
      .i_r    (w_chain[i]),
      .i_g    (gen_poly),
      .o_r    (w_chain[i+1])
    );
  end

  // Parity beat k lane i carries r[ROOTS_NUM-1-(k*bus+i)]; lanes past the
  // end of the remainder (and padding beats) read as zero
  for (genvar k = 0; k < PAD_BEATS; k++) begin : g_pbeat
    for (genvar i = 0; i < BUS_WIDTH_IN_SYMB; i++) begin : g_plane
      localparam int IDX = k * BUS_WIDTH_IN_SYMB + i;
      if (IDX < ROOTS_NUM) begin : g_sym
        assign w_beats[k][i*SYMB_WIDTH +: SYMB_WIDTH] = r_parity[ROOTS_NUM-1-IDX];
      end else begin : g_pad
        assign w_beats[k][i*SYMB_WIDTH +: SYMB_WIDTH] = '0;
      end
    end
  end

  assign w_par_data = w_beats[r_cnt];
  assign w_par_last = (r_cnt == CNT_LAST);

  // Phase register and parity beat counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_DATA;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next phase: leave DATA on the last message beat, leave PARITY once the
  // final parity beat is loaded into the output register
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_DATA: begin
        if (w_s_fire && s_axis.tlast) w_state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        if (w_out_free) begin
          if (w_par_last) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_DATA;
    endcase
  end

  // Remainder accumulation; cleared at packet end so the next packet can
  // follow immediately, with the final remainder parked for emission
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_lfsr   <= '0;
      r_parity <= '0;
    end else if (w_s_fire) begin
      if (s_axis.tlast) begin
        r_lfsr   <= '0;
        r_parity <= w_chain[BUS_WIDTH_IN_SYMB];
      end else begin
        r_lfsr <= w_chain[BUS_WIDTH_IN_SYMB];
      end
    end
  end

  // Registered output stage: parity beats, pass-through beats, or drain
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tkeep  <= '0;
    end else if (r_state == ST_PARITY && w_out_free) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_par_data;
      r_m_tlast  <= w_par_last;
      r_m_tkeep  <= w_par_last ? LAST_KEEP : '1;
    end else if (w_s_fire) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_axis.tdata;
      r_m_tlast  <= 1'b0;
      r_m_tkeep  <= s_axis.tkeep;
    end else if (m_axis.tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_encoder_lfsr.sv
// Bench for rs_encoder_lfsr: one instance with 2 parity symbols and one with
// 6. The expected stream comes from polynomial long division of the message
// by g(x); every emitted codeword is also evaluated at the generator roots.
module tb_rs_encoder_lfsr;
  import gf_pkg::*;

  localparam int SW = SYMB_WIDTH;
  localparam int NB = BUS_WIDTH_IN_SYMB;
  localparam int W  = 1 + NB + NB * SW;
  localparam int R0 = 2;
  localparam int R1 = 6;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  int   cyc     = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  rs_encoder_lfsr_if s0 ();
  rs_encoder_lfsr_if m0 ();
  rs_encoder_lfsr_if s1 ();
  rs_encoder_lfsr_if m1 ();

  logic [R0-1:0][SW-1:0] gp0;
  logic [R1-1:0][SW-1:0] gp1;
  rs_state_e dbg0, dbg1;

  rs_encoder_lfsr #(.ROOTS_NUM(R0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .gen_poly(gp0),
    .s_axis(s0.slave), .m_axis(m0.master), .o_dbg_state(dbg0)
  );

  rs_encoder_lfsr #(.ROOTS_NUM(R1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .gen_poly(gp1),
    .s_axis(s1.slave), .m_axis(m1.master), .o_dbg_state(dbg1)
  );

  logic             d_valid [2];
  logic             d_last  [2];
  logic [NB*SW-1:0] d_data  [2];
  logic [NB-1:0]    d_keep  [2];
  logic             d_rdy   [2];
  bit               rdy_rand  [2] = '{0, 0};
  logic             rdy_force [2] = '{1'b1, 1'b1};

  assign s0.tvalid = d_valid[0];
  assign s0.tdata  = d_data[0];
  assign s0.tlast  = d_last[0];
  assign s0.tkeep  = d_keep[0];
  assign m0.tready = d_rdy[0];
  assign s1.tvalid = d_valid[1];
  assign s1.tdata  = d_data[1];
  assign s1.tlast  = d_last[1];
  assign s1.tkeep  = d_keep[1];
  assign m1.tready = d_rdy[1];

  logic             o_valid  [2];
  logic             o_last   [2];
  logic [NB*SW-1:0] o_data   [2];
  logic [NB-1:0]    o_keep   [2];
  logic             o_sready [2];
  rs_state_e        o_dbg    [2];

  assign o_valid[0] = m0.tvalid;  assign o_valid[1] = m1.tvalid;
  assign o_last[0]  = m0.tlast;   assign o_last[1]  = m1.tlast;
  assign o_data[0]  = m0.tdata;   assign o_data[1]  = m1.tdata;
  assign o_keep[0]  = m0.tkeep;   assign o_keep[1]  = m1.tkeep;
  assign o_sready[0] = s0.tready; assign o_sready[1] = s1.tready;
  assign o_dbg[0]   = dbg0;       assign o_dbg[1]   = dbg1;

  // ---------------- reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] gm [2][8];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] gpow(input int k);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < k; i++) v = gmul(v, 8'h02);
    return v;
  endfunction

  function automatic int roots(input int d);
    return (d == 0) ? R0 : R1;
  endfunction

  function automatic logic [NB-1:0] kmask(input int n);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [W-1:0] mask_beat(input logic [W-1:0] b);
    logic [W-1:0] r;
    r = b;
    for (int i = 0; i < NB; i++) if (!b[NB*SW+i]) r[i*SW +: SW] = '0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0 [$];
  logic [W-1:0] exp_q1 [$];
  logic [7:0]   cw0 [$];
  logic [7:0]   cw1 [$];
  logic         hold_v    [2] = '{1'b0, 1'b0};
  logic [W-1:0] hold_beat [2];
  logic [W-1:0] last_beat [2];
  logic [W-1:0] prev_beat [2];
  int           first_acc [2];
  int           last_acc  [2];

  task automatic push_exp(input int d, input logic [W-1:0] b);
    if (d == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic mon_step(input int d);
    logic [W-1:0] beat, expb;
    logic [7:0]   acc;
    logic [7:0]   cw [$];
    int           qs;
    beat = {o_last[d], o_keep[d], o_data[d]};
    if (hold_v[d]) check("hold_stable", {o_valid[d], beat}, {1'b1, hold_beat[d]});
    hold_v[d]    = o_valid[d] && !d_rdy[d];
    hold_beat[d] = beat;
    if (o_dbg[d] == ST_PARITY) check("s_tready_in_parity", o_sready[d], 1'b0);
    if (o_valid[d] && d_rdy[d]) begin
      qs = qsize(d);
      check("beat_expected", qs != 0, 1'b1);
      if (qs != 0) begin
        if (d == 0) expb = exp_q0.pop_front(); else expb = exp_q1.pop_front();
        check("out_beat", mask_beat(beat), mask_beat(expb));
      end
      prev_beat[d] = last_beat[d];
      last_beat[d] = beat;
      for (int i = 0; i < NB; i++) begin
        if (o_keep[d][i]) begin
          if (d == 0) cw0.push_back(o_data[d][i*SW +: SW]);
          else        cw1.push_back(o_data[d][i*SW +: SW]);
        end
      end
      if (o_last[d]) begin
        if (d == 0) cw = cw0; else cw = cw1;
        for (int k = 1; k <= roots(d); k++) begin
          acc = '0;
          for (int i = 0; i < cw.size(); i++) acc = gmul(acc, gpow(k)) ^ cw[i];
          check("syndrome", acc, 8'h00);
        end
        if (d == 0) cw0.delete(); else cw1.delete();
      end
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      mon_step(0);
      mon_step(1);
    end
  end

  // m_tready driver: forced level or 50% random
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      for (int d = 0; d < 2; d++)
        d_rdy[d] = rdy_rand[d] ? 1'($urandom_range(0, 1)) : rdy_force[d];
    end
  end

  // ---------------- driver ----------------
  // mode 0: random symbols, 1: all zero, 2: single 0x01 in lane 0.
  // abort_at >= 0 stops before driving that beat (no parity expected).
  task automatic send_packet(input int d, input int nbeats, input int lastk,
                             input int mode, input int abort_at);
    logic [7:0]       msg [$];
    logic [7:0]       bufq [$];
    logic [NB*SW-1:0] data;
    logic [NB-1:0]    keep;
    logic [7:0]       sym, coef;
    int               t, r, n, p;
    for (int b = 0; b < nbeats; b++) begin
      if (b == abort_at) begin
        d_valid[d] = 1'b0;
        return;
      end
      keep = (b == nbeats - 1) ? kmask(lastk) : '1;
      for (int i = 0; i < NB; i++) begin
        case (mode)
          0:       sym = 8'($urandom_range(0, 255));
          2:       sym = (b == 0 && i == 0) ? 8'h01 : 8'h00;
          default: sym = 8'h00;
        endcase
        data[i*SW +: SW] = sym;
        if (keep[i]) msg.push_back(sym);
      end
      push_exp(d, {1'b0, keep, data});
      d_valid[d] = 1'b1;
      d_data[d]  = data;
      d_keep[d]  = keep;
      d_last[d]  = (b == nbeats - 1);
      t = 0;
      @(negedge aclk);
      while (!o_sready[d] && t < 300) begin
        t++;
        @(negedge aclk);
      end
      check("accept_timeout", t < 300, 1'b1);
      if (t >= 300) begin
        d_valid[d] = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
      if (b == 0) first_acc[d] = cyc;
      last_acc[d] = cyc;
    end
    d_valid[d] = 1'b0;
    // Remainder of msg(x) * x^R divided by g(x), by long division
    r = roots(d);
    n = msg.size();
    bufq = msg;
    for (int j = 0; j < r; j++) bufq.push_back(8'h00);
    for (int i = 0; i < n; i++) begin
      coef = bufq[i];
      for (int j = 1; j <= r; j++) bufq[i+j] = bufq[i+j] ^ gmul(coef, gm[d][r-j]);
    end
    p = (r + NB - 1) / NB;
    for (int k = 0; k < p; k++) begin
      data = '0;
      for (int i = 0; i < NB; i++)
        if (k * NB + i < r) data[i*SW +: SW] = bufq[n + k*NB + i];
      keep = (k == p - 1) ? kmask(((r - 1) % NB) + 1) : '1;
      push_exp(d, {(k == p - 1), keep, data});
    end
  endtask

  task automatic wait_drain(input int d);
    int t;
    t = 0;
    while (qsize(d) != 0 && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    check("drain_timeout", qsize(d), 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic check_idle_outputs(input int d);
    check("rst_m_tvalid", o_valid[d], 1'b0);
    check("rst_m_tdata", o_data[d], '0);
    check("rst_m_tkeep", o_keep[d], '0);
    check("rst_m_tlast", o_last[d], 1'b0);
    check("rst_state", o_dbg[d], ST_DATA);
  endtask

  // ---------------- directed sequence ----------------
  int a_last;

  initial begin
    for (int d = 0; d < 2; d++) begin
      d_valid[d] = 1'b0; d_last[d] = 1'b0; d_data[d] = '0; d_keep[d] = '0;
      d_rdy[d] = 1'b1;
    end
    // g(x) for R0 given directly; for R1 built as prod (x - alpha^k), k=1..6
    gm[0][0] = 8'h08; gm[0][1] = 8'h06;
    gp0[0] = 8'h08;   gp0[1] = 8'h06;
    begin
      logic [7:0] c [8];
      for (int j = 0; j < 8; j++) c[j] = 8'h00;
      c[0] = 8'h01;
      for (int k = 1; k <= R1; k++) begin
        for (int j = k; j >= 1; j--) c[j] = c[j-1] ^ gmul(gpow(k), c[j]);
        c[0] = gmul(gpow(k), c[0]);
      end
      for (int j = 0; j < R1; j++) begin
        gm[1][j] = c[j];
        gp1[j]   = c[j];
      end
    end

    repeat (3) @(posedge aclk);
    #1;
    check_idle_outputs(0);
    check_idle_outputs(1);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check_idle_outputs(0);
    check("s_tready_after_reset0", o_sready[0], 1'b1);
    check("s_tready_after_reset1", o_sready[1], 1'b1);

    // Single symbol 0x01 -> parity {0x06, 0x08}
    send_packet(0, 1, 1, 2, -1);
    wait_drain(0);
    check("single_par_data", last_beat[0][15:0], 16'h0806);
    check("single_par_keep", last_beat[0][NB*SW +: NB], 4'b0011);
    check("single_par_last", last_beat[0][W-1], 1'b1);
    check("single_data_lane0", prev_beat[0][7:0], 8'h01);
    check("single_data_keep", prev_beat[0][NB*SW +: NB], 4'b0001);
    check("single_data_last", prev_beat[0][W-1], 1'b0);

    // All-zero message, full-rate acceptance
    send_packet(0, 3, 4, 1, -1);
    check("zero_pkt_throughput", last_acc[0] - first_acc[0], 2);
    wait_drain(0);
    check("zero_par_data", last_beat[0][15:0], 16'h0000);
    check("zero_par_keep", last_beat[0][NB*SW +: NB], 4'b0011);

    // Two parity beats, then a back-to-back packet
    send_packet(1, 3, 2, 0, -1);
    a_last = last_acc[1];
    send_packet(1, 2, 4, 0, -1);
    check("b2b_gap", first_acc[1] - a_last, 3);
    wait_drain(1);
    check("mb_last_keep", last_beat[1][NB*SW +: NB], 4'b0011);
    check("mb_last_tlast", last_beat[1][W-1], 1'b1);
    check("mb_prev_keep", prev_beat[1][NB*SW +: NB], 4'b1111);
    check("mb_prev_tlast", prev_beat[1][W-1], 1'b0);

    // m_tready held low while parity is pending
    rdy_force[1] = 1'b0;
    @(posedge aclk);
    #1;
    send_packet(1, 1, 3, 0, -1);
    repeat (10) begin
      @(negedge aclk);
      check("hold_state_parity", o_dbg[1], ST_PARITY);
      check("hold_valid", o_valid[1], 1'b1);
    end
    rdy_force[1] = 1'b1;
    wait_drain(1);

    // Random packets under random backpressure
    rdy_rand[0] = 1;
    rdy_rand[1] = 1;
    for (int k = 0; k < 200; k++)
      send_packet(0, $urandom_range(1, 16), $urandom_range(1, NB), 0, -1);
    for (int k = 0; k < 40; k++)
      send_packet(1, $urandom_range(1, 16), $urandom_range(1, NB), 0, -1);
    wait_drain(0);
    wait_drain(1);
    rdy_rand[0] = 0;
    rdy_rand[1] = 0;
    @(posedge aclk);
    #1;

    // Reset in the middle of a 5-beat packet
    send_packet(0, 5, 4, 0, 2);
    aresetn = 1'b0;
    #1;
    check_idle_outputs(0);
    exp_q0.delete(); exp_q1.delete();
    cw0.delete();    cw1.delete();
    hold_v[0] = 1'b0; hold_v[1] = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send_packet(0, 1, 1, 2, -1);
    wait_drain(0);
    check("post_reset_par_data", last_beat[0][15:0], 16'h0806);
    check("post_reset_par_last", last_beat[0][W-1], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
